// File: rtl/tmr_pipe_stage.sv
`default_nettype none
// =============================================================================
// Module  : tmr_pipe_stage
// Purpose : Triplicated register pipeline with per-replica voters, mismatch
//           reporting and a saturating upset counter.
//           Optional macro TMR_SCRUB_EN: stalled replicas reload their stage vote.
// Rev     : 1.0
// =============================================================================
module tmr_pipe_stage #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             err_pulse,
  output logic [2:0]       err_replica,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam int               WW      = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [STAGES-1:0][2:0][WW-1:0] rep_q;
  logic [STAGES-1:0][2:0][WW-1:0] vote;
  logic [STAGES-1:0][2:0]         mism;
  logic [2:0]                     rep_mism;
  logic                           any_mism;
  logic [WW-1:0]                  out_word;

  function automatic logic [WW-1:0] maj3(input logic [WW-1:0] a,
                                         input logic [WW-1:0] b,
                                         input logic [WW-1:0] c);
    return (a & b) | (b & c) | (c & a);
  endfunction

  // Each replica owns its own voter, so a voter upset only corrupts one lane.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    for (genvar r = 0; r < 3; r++) begin : g_rep
      logic [WW-1:0] q;
      logic [WW-1:0] load_src;
      logic [WW-1:0] hold_src;

      assign rep_q[k][r] = q;
      assign vote[k][r]  = maj3(rep_q[k][0], rep_q[k][1], rep_q[k][2]);
      assign mism[k][r]  = |(rep_q[k][r] ^ vote[k][r]);

      if (k == 0) begin : g_head
        assign load_src = {in_valid, in_data};
      end else begin : g_body
        assign load_src = vote[k-1][r];
      end

`ifdef TMR_SCRUB_EN
      assign hold_src = vote[k][r];
`else
      assign hold_src = q;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (en) begin
          q <= load_src;
        end else begin
          q <= hold_src;
        end
      end
    end
  end

  always_comb begin
    rep_mism = '0;
    for (int k = 0; k < STAGES; k++) begin
      rep_mism = rep_mism | mism[k];
    end
  end

  assign any_mism = |rep_mism;

  // Second vote level over the last stage's three voters.
  assign out_word  = maj3(vote[STAGES-1][0], vote[STAGES-1][1], vote[STAGES-1][2]);
  assign out_valid = out_word[WIDTH];
  assign out_data  = out_word[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse   <= 1'b0;
      err_replica <= '0;
      err_count   <= '0;
    end else begin
      err_pulse <= any_mism;
      if (err_clr) begin
        err_replica <= rep_mism;
        err_count   <= any_mism ? CNT_W'(1) : '0;
      end else begin
        err_replica <= err_replica | rep_mism;
        if (any_mism && (err_count != CNT_MAX)) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmr_pipe_stage.sv
`default_nettype none
// Bench for tmr_pipe_stage: vector table, replica fault-injection sequences and a
// random run, all compared against a cycle-level pipeline and error-log model.
module tb_tmr_pipe_stage;

  localparam int W        = 8;
  localparam int S        = 2;
  localparam int MAX_MAIN = 255;
  localparam int MAX_SAT  = 3;

  logic         clk = 1'b0;
  logic         rst_n, en, in_valid, err_clr;
  logic [W-1:0] in_data;

  logic         out_valid, err_pulse;
  logic [W-1:0] out_data;
  logic [2:0]   err_replica;
  logic [7:0]   err_count;

  logic         s_out_valid, s_err_pulse;
  logic [W-1:0] s_out_data;
  logic [2:0]   s_err_replica;
  logic [1:0]   s_err_count;

  tmr_pipe_stage #(.WIDTH(W), .STAGES(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .err_pulse(err_pulse),
    .err_replica(err_replica), .err_count(err_count), .err_clr(err_clr)
  );

  tmr_pipe_stage #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .err_pulse(s_err_pulse),
    .err_replica(s_err_replica), .err_count(s_err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: ideal pipeline contents plus the error log implied by the
  // set of replicas the bench currently knows to be corrupted.
  logic [W:0] mpipe [S];
  int         mcnt, mcnt_sat;
  logic [2:0] mrep, mrep_sat;
  logic       mpulse, mpulse_sat;
  logic [2:0] flt, flt_sat;

  logic [W:0] f_s1r2, f_s0r0, f_s1r1, f_sat_s0r1;

  typedef struct {
    logic         en;
    logic         vld;
    logic [W-1:0] data;
    logic         exp_vld;
    logic [W-1:0] exp_data;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < S; k++) mpipe[k] = '0;
    mcnt = 0; mcnt_sat = 0;
    mrep = '0; mrep_sat = '0;
    mpulse = 1'b0; mpulse_sat = 1'b0;
  endtask

  task automatic model_edge();
    logic any_m, any_s;
    any_m = |flt;
    any_s = |flt_sat;
    if (en) begin
      for (int k = S - 1; k > 0; k--) mpipe[k] = mpipe[k-1];
      mpipe[0] = {in_valid, in_data};
    end
    mpulse     = any_m;
    mpulse_sat = any_s;
    if (err_clr) begin
      mrep = flt;         mcnt     = any_m ? 1 : 0;
      mrep_sat = flt_sat; mcnt_sat = any_s ? 1 : 0;
    end else begin
      mrep     = mrep | flt;
      mrep_sat = mrep_sat | flt_sat;
      if (any_m && mcnt < MAX_MAIN) mcnt++;
      if (any_s && mcnt_sat < MAX_SAT) mcnt_sat++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " out_valid"},     32'(out_valid),     32'(mpipe[S-1][W]));
    chk({tag, " out_data"},      32'(out_data),      32'(mpipe[S-1][W-1:0]));
    chk({tag, " err_pulse"},     32'(err_pulse),     32'(mpulse));
    chk({tag, " err_replica"},   32'(err_replica),   32'(mrep));
    chk({tag, " err_count"},     32'(err_count),     32'(mcnt));
    chk({tag, " sat out_valid"}, 32'(s_out_valid),   32'(mpipe[S-1][W]));
    chk({tag, " sat out_data"},  32'(s_out_data),    32'(mpipe[S-1][W-1:0]));
    chk({tag, " sat err_pulse"}, 32'(s_err_pulse),   32'(mpulse_sat));
    chk({tag, " sat err_rep"},   32'(s_err_replica), 32'(mrep_sat));
    chk({tag, " sat err_count"}, 32'(s_err_count),   32'(mcnt_sat));
  endtask

  // Upsets are modelled by forcing a replica; releasing re-forces the value the
  // replica should hold afterwards so the outcome is independent of release style.
  task automatic set_s1r2(input logic [W:0] v);
    f_s1r2 = v;
    force dut.g_stage[1].g_rep[2].q = f_s1r2;
  endtask
  task automatic rel_s1r2(input logic [W:0] v);
    f_s1r2 = v;
    force dut.g_stage[1].g_rep[2].q = f_s1r2;
    release dut.g_stage[1].g_rep[2].q;
  endtask
  task automatic set_s0r0(input logic [W:0] v);
    f_s0r0 = v;
    force dut.g_stage[0].g_rep[0].q = f_s0r0;
  endtask
  task automatic rel_s0r0(input logic [W:0] v);
    f_s0r0 = v;
    force dut.g_stage[0].g_rep[0].q = f_s0r0;
    release dut.g_stage[0].g_rep[0].q;
  endtask
  task automatic set_s1r1(input logic [W:0] v);
    f_s1r1 = v;
    force dut.g_stage[1].g_rep[1].q = f_s1r1;
  endtask
  task automatic rel_s1r1(input logic [W:0] v);
    f_s1r1 = v;
    force dut.g_stage[1].g_rep[1].q = f_s1r1;
    release dut.g_stage[1].g_rep[1].q;
  endtask
  task automatic set_sat_s0r1(input logic [W:0] v);
    f_sat_s0r1 = v;
    force dut_sat.g_stage[0].g_rep[1].q = f_sat_s0r1;
  endtask
  task automatic rel_sat_s0r1(input logic [W:0] v);
    f_sat_s0r1 = v;
    force dut_sat.g_stage[0].g_rep[1].q = f_sat_s0r1;
    release dut_sat.g_stage[0].g_rep[1].q;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
    flt = '0; flt_sat = '0;
    model_reset();

    vt[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'hA5};
    vt[2] = '{1'b0, 1'b0, 8'hFF, 1'b1, 8'hA5};
    vt[3] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'hA5};
    vt[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h3C};
    vt[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vt[6] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00};
    vt[7] = '{1'b1, 1'b1, 8'hC3, 1'b1, 8'h5A};
    vt[8] = '{1'b1, 1'b0, 8'h7E, 1'b1, 8'hC3};
    vt[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h7E};

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Latency, hold and valid/data propagation from the vector table.
    for (int i = 0; i < 10; i++) begin
      en = vt[i].en; in_valid = vt[i].vld; in_data = vt[i].data;
      tick();
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].exp_vld));
      chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vt[i].exp_data));
      chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'h0);
      check_all($sformatf("vec%0d", i));
    end

    // Single-cycle upset in a last-stage replica while streaming.
    en = 1'b1; in_valid = 1'b1;
    in_data = 8'h5A; tick();
    in_data = 8'h96; tick();
    set_s1r2(mpipe[1] ^ 9'h008); flt = 3'b100;
    in_data = 8'h33;
    #1;
    chk("T2 masked out_data", 32'(out_data), 32'(mpipe[1][W-1:0]));
    tick();
    rel_s1r2(mpipe[1]); flt = '0;
    #1;
    check_all("T2 edge");
    chk("T2 out_data",    32'(out_data),    32'h96);
    chk("T2 err_pulse",   32'(err_pulse),   32'h1);
    chk("T2 err_replica", 32'(err_replica), 32'h4);
    chk("T2 err_count",   32'(err_count),   32'h1);
    tick();
    check_all("T2 after");
    chk("T2 pulse drops", 32'(err_pulse), 32'h0);
    chk("T2 count holds", 32'(err_count), 32'h1);

    // Plain clear, then an upset in stage 0 while stalled.
    en = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr err_count",   32'(err_count),   32'h0);
    chk("clr err_replica", 32'(err_replica), 32'h0);
    set_s0r0(mpipe[0] ^ 9'h001); flt = 3'b001;
    in_data = 8'hE7; in_valid = 1'b0;
    tick();
    check_all("T3 first");
`ifdef TMR_SCRUB_EN
    rel_s0r0(mpipe[0]); flt = '0;
`else
    rel_s0r0(mpipe[0] ^ 9'h001);
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("T3 hold%0d", i));
    end
    chk("T3 out held", 32'(out_data), 32'h33);
`ifdef TMR_SCRUB_EN
    chk("T3 err_count", 32'(err_count), 32'h1);
`else
    chk("T3 err_count", 32'(err_count), 32'h5);
`endif
    en = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    tick();
    flt = '0;
    check_all("T3 resume");
`ifdef TMR_SCRUB_EN
    chk("T3 resume count", 32'(err_count), 32'h1);
`else
    chk("T3 resume count", 32'(err_count), 32'h6);
`endif

    // Clear coincident with a fresh upset: log restarts from this cycle only.
    in_data = 8'h55;
    set_s1r1(mpipe[1] ^ 9'h010); flt = 3'b010;
    err_clr = 1'b1;
    tick();
    rel_s1r1(mpipe[1]); flt = '0;
    #1;
    check_all("T5 clr+fault");
    chk("T5 err_count",   32'(err_count),   32'h1);
    chk("T5 err_replica", 32'(err_replica), 32'h2);
    tick();
    err_clr = 1'b0;
    check_all("T5 clr only");
    chk("T5 cleared count",   32'(err_count),   32'h0);
    chk("T5 cleared replica", 32'(err_replica), 32'h0);

    // Stuck replica on the 2-bit counter instance: saturate at 3.
    in_valid = 1'b1; in_data = 8'h3C;
    tick(); tick();
    set_sat_s0r1(9'h13C ^ 9'h100); flt_sat = 3'b010;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all($sformatf("T4 cyc%0d", i));
      chk($sformatf("T4 sat count%0d", i), 32'(s_err_count), (i < 2) ? 32'(i + 1) : 32'h3);
    end
    rel_sat_s0r1(9'h13C); flt_sat = '0;
    tick();
    check_all("T4 after");
    chk("T4 no wrap", 32'(s_err_count), 32'h3);
    chk("T4 sat out", 32'(s_out_data),  32'h3C);

    // Asynchronous reset with valid data in flight and a non-zero log.
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("T6 async");
    chk("T6 out_valid",  32'(out_valid),   32'h0);
    chk("T6 sat count",  32'(s_err_count), 32'h0);
    #2;
    rst_n = 1'b1;
    en = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    chk("T6 latency gap", 32'(out_valid), 32'h0);
    in_data = 8'h78;
    tick();
    chk("T6 resume valid", 32'(out_valid), 32'h1);
    chk("T6 resume data",  32'(out_data),  32'h77);
    check_all("T6 resume");

    // Random traffic, stalls and clears with no upsets.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = 8'($urandom);
      err_clr  = ($urandom_range(0, 19) == 0);
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
